// File: rtl/alu_console_pkg.sv
// Shared definitions for the ALU console: operation encodings and hex glyphs.
package alu_console_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Active-low seven-segment glyphs, bit 7 = dp (off), entry n at [n].
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/alu_console_seg_scan.sv
// Multiplexed seven-segment scanner: walks one active-low digit enable across
// the display word and shows the matching nibble as a hex glyph.
module seg_scan
  import alu_console_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_BITS = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   word,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            segment
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           nib;
  logic [7:0]           glyph;

  // Scan counter, digit index advance on counter wrap, and next display outputs.
  always_comb begin
    cnt_d = cnt_q + SCAN_BITS'(1);
    idx_d = idx_q;
    if (cnt_q == '1) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    nib   = word[4*int'(idx_q) +: 4];
    glyph = hex_glyph(nib);
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = {1'b1, glyph[6:0]};
  end

  // State and registered display outputs; reset shows digit 0 as '0'.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= ~DIGITS'(1);
      seg_q <= 8'hC0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an      = an_q;
  assign segment = seg_q;

endmodule

// File: rtl/alu_console.sv
// Button-driven ALU console: two operands stepped by buttons, a registered ALU
// result, and a scanned seven-segment display of {A, B, 000, C, R}.
// Optional build macro ALU_CONSOLE_AUTOREPEAT_EN adds per-button auto-repeat.
module alu_console
  import alu_console_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SCAN_BITS  = 17,
  parameter int unsigned REPEAT_CYC = 4194304,
  localparam int unsigned DIGITS    = 3*WIDTH/4 + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn,
  input  logic [2:0]        op,
  output logic [DIGITS-1:0] AN,
  output logic [7:0]        SEGMENT
);

  logic [3:0]       btn_q, btn_d;
  logic [3:0]       edge_c;
  logic [3:0]       pulse;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   sum;
  logic [4*DIGITS-1:0] word;

  // History always follows btn, so a button held through reset loads as 1
  // and its release from reset produces no edge.
  always_comb begin
    btn_d  = btn;
    edge_c = btn & ~btn_q;
  end

  always_ff @(posedge clk) begin
    btn_q <= btn_d;
  end

`ifdef ALU_CONSOLE_AUTOREPEAT_EN
  localparam int unsigned RC_W = $clog2(REPEAT_CYC + 1);

  logic [3:0][RC_W-1:0] rep_q, rep_d;
  logic [3:0]           rep_hit;

  // Per-button hold counters; each terminal count emits one extra pulse.
  always_comb begin
    rep_d   = rep_q;
    rep_hit = '0;
    for (int i = 0; i < 4; i++) begin
      if (!btn[i] || edge_c[i]) begin
        rep_d[i] = '0;
      end else if (rep_q[i] == RC_W'(REPEAT_CYC - 1)) begin
        rep_d[i]   = '0;
        rep_hit[i] = 1'b1;
      end else begin
        rep_d[i] = rep_q[i] + RC_W'(1);
      end
    end
    pulse = edge_c | rep_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  // Only rising edges step the operands.
  always_comb begin
    pulse = edge_c;
  end
`endif

  // Operand stepping; opposing pulses on one operand cancel.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    case ({pulse[2], pulse[0]})
      2'b01:   a_d = a_q + WIDTH'(1);
      2'b10:   a_d = a_q - WIDTH'(1);
      default: a_d = a_q;
    endcase
    case ({pulse[3], pulse[1]})
      2'b01:   b_d = b_q + WIDTH'(1);
      2'b10:   b_d = b_q - WIDTH'(1);
      default: b_d = b_q;
    endcase
  end

  // ALU: carry only meaningful for ADD/SUB, SUB carry is the no-borrow flag.
  always_comb begin
    r_d = '0;
    c_d = 1'b0;
    sum = '0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        {c_d, r_d} = sum;
      end
      OP_SUB: begin
        sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        {c_d, r_d} = sum;
      end
      OP_AND:  r_d = a_q & b_q;
      OP_OR:   r_d = a_q | b_q;
      OP_XOR:  r_d = a_q ^ b_q;
      OP_NOR:  r_d = ~(a_q | b_q);
      OP_SLT:  r_d = WIDTH'(a_q < b_q);
      OP_PASS: r_d = a_q;
      default: r_d = '0;
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign word = {a_q, b_q, 3'b000, c_q, r_q};

  seg_scan #(
    .DIGITS    (DIGITS),
    .SCAN_BITS (SCAN_BITS)
  ) u_seg_scan (
    .clk     (clk),
    .rst     (rst),
    .word    (word),
    .an      (AN),
    .segment (SEGMENT)
  );

endmodule
